debounce_sync: RTL and testbench
================================

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on raw_i; legal values are 2..4.
REQ-002 Parameter STABLE_CYCLES, default 4: number of consecutive identical synchronized samples required to accept a new level; legal values are 2..65535.
REQ-003 Port clk_i, input, 1 bit: the single clock; every flop is rising-edge triggered.
REQ-004 Port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port raw_i, input, 1 bit: asynchronous, possibly bouncing input such as a pushbutton.
REQ-006 Port level_o, output, 1 bit: debounced level, registered.
REQ-007 Port rise_o, output, 1 bit: single-cycle pulse when level_o changes 0->1, registered; intended to drive a downstream D-FF enable.
REQ-008 Port fall_o, output, 1 bit: single-cycle pulse when level_o changes 1->0, registered.
REQ-009 Port busy_o, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-010 raw_i SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is called sync_s, and no other logic samples raw_i.
REQ-011 The FSM SHALL have four states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
REQ-012 A counter cnt SHALL be $clog2(STABLE_CYCLES) bits wide, unsigned, and saturation-free; it never exceeds STABLE_CYCLES-1.
REQ-013 In S_LOW with sync_s=1, the FSM SHALL go to S_WAIT_HIGH with cnt=1; with sync_s=0 it SHALL stay in S_LOW with cnt=0.
REQ-014 In S_WAIT_HIGH with sync_s=0 (glitch), the FSM SHALL return to S_LOW with cnt=0, and no pulse is produced.
REQ-015 In S_WAIT_HIGH with sync_s=1 and cnt<STABLE_CYCLES-1, cnt SHALL increment by 1.
REQ-016 In S_WAIT_HIGH with sync_s=1 and cnt==STABLE_CYCLES-1, the FSM SHALL go to S_HIGH, set level_o=1, assert rise_o for exactly one cycle, and set cnt=0.
REQ-017 S_HIGH and S_WAIT_LOW SHALL mirror REQ-013 to REQ-016 with polarities inverted, with fall_o replacing rise_o.
REQ-018 Latency: after raw_i changes and holds before rising edge 0, level_o and the pulse SHALL update at rising edge SYNC_STAGES+STABLE_CYCLES-1 (edge 5 for the defaults).
REQ-019 rise_o and fall_o SHALL never be high simultaneously, and neither shall be high for two consecutive cycles.
REQ-020 busy_o SHALL be 1 exactly in states S_WAIT_HIGH and S_WAIT_LOW.
REQ-021 Bounce: any sync_s toggle during a WAIT state SHALL restart qualification from the stable state; level_o holds its value throughout.
REQ-022 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-023 While rst_ni=0, all synchronizer flops, the state (S_LOW), cnt, level_o, rise_o, fall_o and busy_o SHALL be 0 immediately, independent of clk_i.
REQ-024 Reset asserted mid-qualification SHALL abort it with no pulse generated.
REQ-025 If raw_i=1 when reset is released, the block SHALL report level_o=1 with a rise_o pulse after the normal REQ-018 latency, counted from the first edge after release.
REQ-026 Reset release SHALL be synchronized externally; the block itself adds no reset synchronizer.

Structure
REQ-027 Package debounce_pkg SHALL hold typedef enum logic [1:0] state_e and the parameter legality limits (SYNC_MIN=2, SYNC_MAX=4, STABLE_MIN=2).
REQ-028 The synchronizer SHALL be the sub-module debounce_sync_chain, with parameter STAGES, ports clk_i, rst_ni, d_i and q_o, and a reset value of 0.
REQ-029 The FSM, counter and output registers SHALL reside in debounce_sync; the outputs are driven directly from flops with no combinational path to any output.

Verification
REQ-030 Reset with raw_i=0, then hold raw_i=0 for 20 cycles: level_o, rise_o, fall_o and busy_o all stay 0.
REQ-031 Defaults; raw_i 0->1 before edge 0 and held: busy_o goes high after edge 2, level_o=1 and rise_o=1 after edge 5, and rise_o=0 after edge 6.
REQ-032 Defaults; raw_i pulses high for 2 cycles, then low: busy_o goes high then low, level_o stays 0, and no pulse occurs.
REQ-033 level_o=1; raw_i bounces 1,0,1,0 on successive cycles, then holds 0: exactly one fall_o pulse occurs, 5 edges after the final transition to 0.
REQ-034 rst_ni is dropped mid-clock during S_WAIT_HIGH with cnt=2: all outputs go 0 before the next edge, and no rise_o pulse occurs after release while raw_i=0.
REQ-035 STABLE_CYCLES=16 and SYNC_STAGES=3 with a random raw_i toggling rate: a scoreboard model matches level_o and pulses cycle-exactly over 10000 cycles.

Source files
------------

// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared types and parameter limits for the debounce_sync block.
//   state_e    : debouncer FSM state encoding
//   SYNC_MIN/MAX, STABLE_MIN/MAX : legal ranges for the block parameters
// ---------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_e;

  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;
  localparam int STABLE_MIN = 2;
  localparam int STABLE_MAX = 65535;

endpackage

// File: rtl/debounce_sync_if.sv
// ---------------------------------------------------------------------------
// debounce_sync_if
// Groups the raw input and the debounced outputs of debounce_sync.
//   raw_i   : asynchronous, possibly bouncing input
//   level_o : debounced level
//   rise_o  : one-cycle pulse on a 0->1 change of level_o
//   fall_o  : one-cycle pulse on a 1->0 change of level_o
//   busy_o  : a candidate level change is being qualified
// Modports: master = whoever drives raw_i and consumes the results,
//           slave  = the debouncer itself.
// ---------------------------------------------------------------------------
interface debounce_sync_if;
  logic raw_i;
  logic level_o;
  logic rise_o;
  logic fall_o;
  logic busy_o;

  modport master (
    output raw_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  busy_o
  );

  modport slave (
    input  raw_i,
    output level_o,
    output rise_o,
    output fall_o,
    output busy_o
  );
endinterface

// File: rtl/debounce_sync_chain.sv
// ---------------------------------------------------------------------------
// debounce_sync_chain
// Multi-flop synchronizer bringing an asynchronous bit into the clk_i domain.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, all stages clear to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output (last stage)
// ---------------------------------------------------------------------------
module debounce_sync_chain
  import debounce_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < SYNC_MIN || STAGES > SYNC_MAX) begin : g_bad_stages
    $error("debounce_sync_chain: STAGES=%0d outside %0d..%0d", STAGES, SYNC_MIN, SYNC_MAX);
  end

  logic [STAGES-1:0] stage_reg;
  logic [STAGES-1:0] stage_next;

  // Stage 0 is the only flop that looks at d_i; every later stage takes its
  // predecessor, giving metastability time to resolve.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_next[gi] = d_i;
    end else begin : g_rest
      assign stage_next[gi] = stage_reg[gi-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign q_o = stage_reg[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
// Synchronizes and debounces a raw input. A new level is accepted only after
// STABLE_CYCLES consecutive identical synchronized samples; any disagreeing
// sample during qualification drops back to the current stable state.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (release synchronized upstream)
//   bus    : debounce_sync_if.slave (raw_i in; level_o/rise_o/fall_o/busy_o
//            out, all driven straight from flops)
// Parameters: SYNC_STAGES (2..4), STABLE_CYCLES (2..65535)
// ---------------------------------------------------------------------------
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  debounce_sync_if.slave  bus
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES=%0d outside %0d..%0d", SYNC_STAGES, SYNC_MIN, SYNC_MAX);
  end
  if (STABLE_CYCLES < STABLE_MIN || STABLE_CYCLES > STABLE_MAX) begin : g_bad_stable
    $error("debounce_sync: STABLE_CYCLES=%0d outside %0d..%0d", STABLE_CYCLES, STABLE_MIN, STABLE_MAX);
  end

  localparam int               CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_s;
  state_e           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic             busy_reg;

  debounce_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.raw_i),
    .q_o    (sync_s)
  );

  // The sample that enters a WAIT state already counts as the first stable
  // one (cnt=1), so acceptance happens on the STABLE_CYCLES-th sample.
  // busy_reg is updated alongside the state so it is high exactly in WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_LOW;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      case (state_reg)
        S_LOW: begin
          if (sync_s) begin
            state_reg <= S_WAIT_HIGH;
            cnt_reg   <= CNT_ONE;
            busy_reg  <= 1'b1;
          end else begin
            cnt_reg   <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!sync_s) begin
            state_reg <= S_LOW;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= S_HIGH;
            cnt_reg   <= '0;
            level_reg <= 1'b1;
            rise_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg   <= cnt_reg + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sync_s) begin
            state_reg <= S_WAIT_LOW;
            cnt_reg   <= CNT_ONE;
            busy_reg  <= 1'b1;
          end else begin
            cnt_reg   <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (sync_s) begin
            state_reg <= S_HIGH;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= S_LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            fall_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg   <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= S_LOW;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level_o = level_reg;
  assign bus.rise_o  = rise_reg;
  assign bus.fall_o  = fall_reg;
  assign bus.busy_o  = busy_reg;

endmodule

// File: tb/tb_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_debounce_sync
// Two debouncers (defaults, and SYNC_STAGES=3 / STABLE_CYCLES=16) share one
// raw input. A run-length model of the debounce rule predicts every output
// on every cycle; directed scenarios pin exact edge timing with literals,
// then a long randomized phase with varying toggle rates follows.
// ---------------------------------------------------------------------------
module tb_debounce_sync;

  localparam int NI = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic raw   = 1'b0;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  int ss_of [NI] = '{2, 3};
  int sc_of [NI] = '{4, 16};

  always #5 clk = ~clk;

  debounce_sync_if bus_def ();
  debounce_sync_if bus_big ();

  assign bus_def.raw_i = raw;
  assign bus_big.raw_i = raw;

  debounce_sync #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut_def (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_def)
  );

  debounce_sync #(
    .SYNC_STAGES   (3),
    .STABLE_CYCLES (16)
  ) dut_big (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_big)
  );

  // {level, rise, fall, busy}
  logic [3:0] dut_out [NI];
  assign dut_out[0] = {bus_def.level_o, bus_def.rise_o, bus_def.fall_o, bus_def.busy_o};
  assign dut_out[1] = {bus_big.level_o, bus_big.rise_o, bus_big.fall_o, bus_big.busy_o};

  // Reference model: the FSM only sees raw as it was SYNC_STAGES edges ago.
  // The level flips once STABLE_CYCLES consecutive seen samples disagree with
  // it; any agreeing sample resets the disagreement run.
  bit [3:0] m_hist  [NI];
  bit       m_level [NI];
  bit       m_rise  [NI];
  bit       m_fall  [NI];
  int       m_run   [NI];

  initial begin
    bit seen;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          m_hist[i]  = '0;
          m_level[i] = 1'b0;
          m_rise[i]  = 1'b0;
          m_fall[i]  = 1'b0;
          m_run[i]   = 0;
        end else begin
          seen       = m_hist[i][ss_of[i]-1];
          m_hist[i]  = {m_hist[i][2:0], raw};
          m_rise[i]  = 1'b0;
          m_fall[i]  = 1'b0;
          if (seen != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == sc_of[i]) begin
              m_level[i] = seen;
              m_rise[i]  = seen;
              m_fall[i]  = !seen;
              m_run[i]   = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  initial begin
    logic [3:0] exp_v;
    forever begin
      @(negedge clk);
      cycle++;
      for (int i = 0; i < NI; i++) begin
        exp_v = {m_level[i], m_rise[i], m_fall[i], (m_run[i] != 0)};
        total++;
        if (dut_out[i] !== exp_v) begin
          bad++;
          $display("FAIL model_cmp dut%0d cycle %0d: got lvl/rise/fall/busy=%b want %b",
                   i, cycle, dut_out[i], exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp_b);
    total++;
    if (act !== exp_b) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp_b);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rate;
    int nfall;

    // Reset with raw low; outputs must be zero before any clock edge.
    raw   = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_level", bus_def.level_o, 1'b0);
    chk("rst_rise",  bus_def.rise_o,  1'b0);
    chk("rst_fall",  bus_def.fall_o,  1'b0);
    chk("rst_busy",  bus_def.busy_o,  1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet input for 20 cycles.
    for (int e = 0; e < 20; e++) begin
      after_edge();
      chk("quiet_level", bus_def.level_o, 1'b0);
      chk("quiet_rise",  bus_def.rise_o,  1'b0);
      chk("quiet_fall",  bus_def.fall_o,  1'b0);
      chk("quiet_busy",  bus_def.busy_o,  1'b0);
    end
    $display("scenario quiet done");

    // Clean 0->1 step: busy after edge 2, accepted at edge 5.
    @(negedge clk);
    raw = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      after_edge();
      chk("step_busy",  bus_def.busy_o,  (e >= 2 && e <= 4));
      chk("step_level", bus_def.level_o, (e >= 5));
      chk("step_rise",  bus_def.rise_o,  (e == 5));
      chk("step_fall",  bus_def.fall_o,  1'b0);
    end
    $display("scenario step done");
    repeat (25) @(posedge clk);

    // Bounce 1,0,1,0 then hold 0: single fall_o five edges after final drop.
    @(negedge clk); raw = 1'b1;
    @(negedge clk); raw = 1'b0;
    @(negedge clk); raw = 1'b1;
    @(negedge clk); raw = 1'b0;
    nfall = 0;
    for (int e = 0; e <= 8; e++) begin
      after_edge();
      if (bus_def.fall_o) nfall++;
      chk("bounce_fall",  bus_def.fall_o,  (e == 5));
      chk("bounce_level", bus_def.level_o, (e < 5));
      chk("bounce_rise",  bus_def.rise_o,  1'b0);
    end
    total++;
    if (nfall != 1) begin
      bad++;
      $display("FAIL bounce_fall_count: got %0d want 1", nfall);
    end
    $display("scenario bounce done");
    repeat (25) @(posedge clk);

    // Two-cycle glitch high: busy briefly, no level change, no pulse.
    @(negedge clk);
    raw = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      after_edge();
      chk("glitch_busy",  bus_def.busy_o,  (e == 2 || e == 3));
      chk("glitch_level", bus_def.level_o, 1'b0);
      chk("glitch_rise",  bus_def.rise_o,  1'b0);
      chk("glitch_fall",  bus_def.fall_o,  1'b0);
      if (e == 1) begin
        @(negedge clk);
        raw = 1'b0;
      end
    end
    $display("scenario glitch done");
    repeat (5) @(posedge clk);

    // Reset dropped mid-clock while qualifying (cnt=2 after edge 3).
    @(negedge clk);
    raw = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_busy_before", bus_def.busy_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_level", bus_def.level_o, 1'b0);
    chk("midrst_rise",  bus_def.rise_o,  1'b0);
    chk("midrst_fall",  bus_def.fall_o,  1'b0);
    chk("midrst_busy",  bus_def.busy_o,  1'b0);
    raw = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      after_edge();
      chk("postrst_rise",  bus_def.rise_o,  1'b0);
      chk("postrst_level", bus_def.level_o, 1'b0);
    end
    $display("scenario mid_reset done");

    // Raw already high at reset release: normal latency from first edge.
    @(negedge clk);
    raw = 1'b1;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      after_edge();
      chk("relhigh_rise",  bus_def.rise_o,  (e == 5));
      chk("relhigh_level", bus_def.level_o, (e >= 5));
    end
    $display("scenario release_high done");

    // Randomized phase with a toggle rate that changes every 500 cycles.
    rate = 2;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(4))
          0:       rate = 2;
          1:       rate = 4;
          2:       rate = 12;
          3:       rate = 30;
          default: rate = 200;
        endcase
      end
      @(negedge clk);
      if ($urandom_range(rate - 1) == 0) raw = ~raw;
    end
    @(negedge clk);
    @(negedge clk);
    $display("scenario random done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
